c3lib_gf_clkmux_ctrl: RTL and testbench

- Sequencer and arbiter in front of the glitch-free clock mux; owns the mux select line.
- Arbitrates clock-switch requests from two requesters, e.g. the AVMM config path and the power-management agent.
- Switch sequence: quiesce downstream logic, flip select, wait for the mux's per-domain select synchronisers to settle, release, acknowledge.
- Runs on a free-running controller clock that is independent of both muxed clocks.

---
 rtl/c3lib_gf_clkmux_ctrl_if.sv | 25 ++
 rtl/c3lib_gf_clkmux_ctrl.sv | 151 +++++++++++++++
 tb/tb_c3lib_gf_clkmux_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/c3lib_gf_clkmux_ctrl_if.sv
// Request/acknowledge and mux-control signals of the clock-mux sequencer.
// The slave side belongs to the controller. The master side belongs to the
// requesters and downstream logic.
interface c3lib_gf_clkmux_ctrl_if;
    logic [1:0] i_req;
    logic [1:0] i_req_sel;
    logic [1:0] o_ack;
    logic [1:0] o_ack_err;
    logic       o_quiesce;
    logic       i_idle;
    logic       o_sel_clk;
    logic       o_busy;
    logic       o_timeout;
    logic       i_timeout_clr;

    modport master (
        output i_req, i_req_sel, i_idle, i_timeout_clr,
        input  o_ack, o_ack_err, o_quiesce, o_sel_clk, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_req_sel, i_idle, i_timeout_clr,
        output o_ack, o_ack_err, o_quiesce, o_sel_clk, o_busy, o_timeout
    );
endinterface

// File: rtl/c3lib_gf_clkmux_ctrl.sv
// Sequencer and arbiter in front of the glitch-free clock mux.
// It arbitrates two switch requesters round-robin and quiesces downstream logic.
// It then flips the mux select, waits for the mux synchronisers to settle, and
// acknowledges the requester. Every output is registered.
module c3lib_gf_clkmux_ctrl #(
    parameter bit          RESET_SEL   = 1'b0,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    c3lib_gf_clkmux_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_SWITCH,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic             tgt_q, tgt_d;
    logic             abort_q, abort_d;
    logic             mask_q;
    logic [1:0]       elig;
    logic             timeout_set;

    logic [1:0]       ack_q, ack_d;
    logic [1:0]       ack_err_q, ack_err_d;
    logic             quiesce_q, quiesce_d;
    logic             busy_q, busy_d;
    logic             sel_q, sel_d;
    logic             timeout_q, timeout_d;

    // Next-state logic, arbitration and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        tgt_d       = tgt_q;
        abort_d     = abort_q;
        timeout_set = 1'b0;
        // Arbitration rests for the single IDLE cycle that follows an ack.
        // A stale level request therefore cannot re-trigger immediately.
        elig        = ctrl.i_req & ~{2{mask_q}};

        case (state_q)
            ST_IDLE: begin
                if (elig != 2'b00) begin
                    gnt_d   = (elig == 2'b11) ? ~last_q : elig[1];
                    last_d  = gnt_d;
                    tgt_d   = ctrl.i_req_sel[gnt_d];
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    state_d = (tgt_d == sel_q) ? ST_DONE : ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                cnt_d = cnt_q + 1'b1;
                if (ctrl.i_idle) begin
                    state_d = ST_SWITCH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_DONE;
                    abort_d     = 1'b1;
                    timeout_set = 1'b1;
                end
            end
            ST_SWITCH: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        quiesce_d = (state_d == ST_QUIESCE) || (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
        busy_d    = (state_d != ST_IDLE);
        ack_d     = (state_d == ST_DONE) ? (2'b01 << gnt_d) : 2'b00;
        ack_err_d = abort_d ? ack_d : 2'b00;
        sel_d     = (state_q == ST_SWITCH) ? tgt_q : sel_q;
        timeout_d = timeout_set | (timeout_q & ~ctrl.i_timeout_clr);
    end

    // State register and sequencing context.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            tgt_q   <= RESET_SEL;
            abort_q <= 1'b0;
            mask_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tgt_q   <= tgt_d;
            abort_q <= abort_d;
            mask_q  <= (state_q == ST_DONE);
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q     <= '0;
            ack_err_q <= '0;
            quiesce_q <= 1'b0;
            busy_q    <= 1'b0;
            sel_q     <= RESET_SEL;
            timeout_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            ack_err_q <= ack_err_d;
            quiesce_q <= quiesce_d;
            busy_q    <= busy_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    assign ctrl.o_ack     = ack_q;
    assign ctrl.o_ack_err = ack_err_q;
    assign ctrl.o_quiesce = quiesce_q;
    assign ctrl.o_busy    = busy_q;
    assign ctrl.o_sel_clk = sel_q;
    assign ctrl.o_timeout = timeout_q;

endmodule

// File: tb/tb_c3lib_gf_clkmux_ctrl.sv
// Randomised bench for the clock-mux sequencer.
// The reference model computes each switch's timeline arithmetically at grant
// time: when sel flips, when the ack lands, and whether it aborts.
// Per-cycle expectations are then read from that timeline.
module tb_c3lib_gf_clkmux_ctrl;

    localparam bit RESET_SEL = 1'b0;
    localparam int SETTLE    = 16;
    localparam int TMO       = 255;
    localparam int N_CYC     = 8000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    c3lib_gf_clkmux_ctrl_if bus ();

    c3lib_gf_clkmux_ctrl #(
        .RESET_SEL  (RESET_SEL),
        .SETTLE_CYC (SETTLE),
        .TIMEOUT_CYC(TMO),
        .CNT_W      (8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .ctrl   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model of the current/last transaction
    int g_m, t_done_m, t_sel_m, d_m;
    bit who_m, tgt_m, err_m, dir_m, last_m, sel_m, to_m;

    // requester behaviour
    bit   req_on [2];
    bit   rsel   [2];
    logic idle_v, clr_v;
    bit   rst_next  = 1'b0;
    int   rst_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic reset_model();
        sel_m    = RESET_SEL;
        last_m   = 1'b1;
        to_m     = 1'b0;
        g_m      = cyc - 3;
        t_done_m = cyc - 2;
        t_sel_m  = -1000;
        err_m    = 1'b0;
        dir_m    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_sel",     bus.o_sel_clk, RESET_SEL);
        check_val("rst_quiesce", bus.o_quiesce, 0);
        check_val("rst_ack",     bus.o_ack,     0);
        check_val("rst_ack_err", bus.o_ack_err, 0);
        check_val("rst_busy",    bus.o_busy,    0);
        check_val("rst_timeout", bus.o_timeout, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc  += 2;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic check_cycle();
        bit         act;
        logic [1:0] ack_e;
        if (cyc == t_sel_m) sel_m = tgt_m;
        act   = (cyc > g_m) && (cyc <= t_done_m);
        ack_e = (cyc == t_done_m) ? (who_m ? 2'b10 : 2'b01) : 2'b00;
        check_val("busy",    bus.o_busy,    act);
        check_val("quiesce", bus.o_quiesce, act && !dir_m && (cyc < t_done_m));
        check_val("ack",     bus.o_ack,     ack_e);
        check_val("ack_err", bus.o_ack_err, err_m ? ack_e : 2'b00);
        check_val("sel_clk", bus.o_sel_clk, sel_m);
        check_val("timeout", bus.o_timeout, to_m);
    endtask

    task automatic step_cycle();
        int       c;
        int       r;
        bit [1:0] req_v;
        c = cyc;

        for (int i = 0; i < 2; i++) begin
            if (c == t_done_m && who_m == i) begin
                if ($urandom_range(1, 0) == 0) req_on[i] = 1'b0;
            end else if (c == t_done_m + 1 && who_m == i && req_on[i]) begin
                if ($urandom_range(1, 0) == 0) req_on[i] = 1'b0;
            end else if (req_on[i] && c > g_m && c < t_done_m && who_m == i) begin
                if ($urandom_range(15, 0) == 0) req_on[i] = 1'b0;
            end else if (!req_on[i] && !(c <= t_done_m && who_m == i)) begin
                if ($urandom_range(5, 0) == 0) begin
                    req_on[i] = 1'b1;
                    rsel[i]   = 1'($urandom_range(1, 0));
                end
            end
            if (c > g_m && c < t_done_m && who_m == i && $urandom_range(15, 0) == 0)
                rsel[i] = ~rsel[i];
        end

        if (c > g_m && c < t_done_m && !dir_m) idle_v = ((c - g_m - 1) >= d_m);
        else                                   idle_v = 1'($urandom_range(1, 0));

        if (err_m && c + 1 == t_done_m) clr_v = 1'($urandom_range(1, 0));
        else                            clr_v = ($urandom_range(7, 0) == 0);

        bus.i_req         = {req_on[1], req_on[0]};
        bus.i_req_sel     = {rsel[1], rsel[0]};
        bus.i_idle        = idle_v;
        bus.i_timeout_clr = clr_v;

        to_m = (err_m && c + 1 == t_done_m) ? 1'b1 : (clr_v ? 1'b0 : to_m);

        req_v = {req_on[1], req_on[0]};
        if (c >= t_done_m + 2 && req_v != 2'b00) begin
            who_m   = (req_v == 2'b11) ? ~last_m : req_v[1];
            last_m  = who_m;
            g_m     = c;
            tgt_m   = rsel[who_m];
            err_m   = 1'b0;
            t_sel_m = -1000;
            if (tgt_m == sel_m) begin
                dir_m    = 1'b1;
                t_done_m = c + 1;
            end else begin
                dir_m = 1'b0;
                r = $urandom_range(19, 0);
                if (r < 12)      d_m = $urandom_range(5, 0);
                else if (r < 15) d_m = $urandom_range(TMO - 1, TMO - 4);
                else             d_m = $urandom_range(TMO + 5, TMO);
                if (d_m < TMO) begin
                    t_sel_m  = c + 3 + d_m;
                    t_done_m = t_sel_m + SETTLE;
                end else begin
                    err_m    = 1'b1;
                    t_done_m = c + 1 + TMO;
                end
            end
        end

        if (!rst_next && rst_count < 2 && cyc > 2500 * (rst_count + 1) &&
            !dir_m && !err_m && t_sel_m <= c + 1 && c + 1 < t_done_m) begin
            rst_next  = 1'b1;
            rst_count++;
        end
    endtask

    initial begin
        bus.i_req         = 2'b00;
        bus.i_req_sel     = 2'b00;
        bus.i_idle        = 1'b0;
        bus.i_timeout_clr = 1'b0;
        req_on[0] = 1'b0; req_on[1] = 1'b0;
        rsel[0]   = 1'b0; rsel[1]   = 1'b0;
        reset_model();
        #2;
        do_reset();
        for (int k = 0; k < N_CYC; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            if (rst_next) begin
                rst_next = 1'b0;
                do_reset();
            end
            check_cycle();
            step_cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
